// File: rtl/uart_rx.sv
// uart_rx - serial receive front end of the UART peripheral.
//
// Synchronises the rx pin through two flops and oversamples it at OVERSAMPLE
// ticks per bit. The tick rate is one tick every clock_divisor+1 clk cycles.
// It deframes 5..8 data bits (LSB first), an optional even/odd parity bit and
// one or two stop bits. Each byte goes to the RX queue with one-cycle status
// pulses.
//
// Optional build macro: UART_RX_MAJORITY_VOTE_EN
//   defined   : each bit is the 2-of-3 majority of three consecutive tick
//               samples centred on the middle of the bit.
//   undefined : each bit is a single sample taken at tick OVERSAMPLE/2-1.
`timescale 1ns/1ps

module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] clock_divisor,
  input  logic [1:0]           parity_type,
  input  logic [1:0]           data_bits_count,
  input  logic                 double_stop_bits,
  input  logic                 ready,
  output logic [7:0]           data,
  output logic                 valid,
  output logic                 parity_error,
  output logic                 stop_bit_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int SCW = $clog2(OVERSAMPLE);

  // The sample counter restarts at every bit decision. Later decisions
  // therefore fall one full bit period after the previous one.
  localparam logic [SCW-1:0] BIT_LAST = SCW'(OVERSAMPLE - 1);

`ifdef UART_RX_MAJORITY_VOTE_EN
  // The vote needs the sample at tick OVERSAMPLE/2. The start-bit decision
  // therefore moves one tick later, and the whole frame lattice moves with it.
  localparam logic [SCW-1:0] START_DECIDE = SCW'(OVERSAMPLE / 2);
`else
  localparam logic [SCW-1:0] START_DECIDE = SCW'(OVERSAMPLE / 2 - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // Even parity of a byte; unused MSBs of the shift register are zero.
  function automatic logic par8(input logic [7:0] v);
    par8 = ^v;
  endfunction

`ifdef UART_RX_MAJORITY_VOTE_EN
  // 2-of-3 majority.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction
`endif

  // Synchroniser and derived line value
  logic r_sync1;
  logic r_sync2;
  logic w_rxs;
  logic w_bit;

  // Tick generator
  logic [DIV_WIDTH-1:0] r_tick_cnt;
  logic                 w_tick;

  // Frame configuration, captured on IDLE->START
  logic [DIV_WIDTH-1:0] r_div;
  logic [1:0]           r_par_type;
  logic [1:0]           r_dbc;
  logic                 r_two_stop;
  logic                 w_par_en;
  logic [2:0]           w_last_idx;

  // FSM state and datapath
  state_t               r_state;
  logic [SCW-1:0]       r_samp_cnt;
  logic [2:0]           r_bit_cnt;
  logic [7:0]           r_shift;
  logic                 r_par_err;
  logic                 r_stop_err;
  logic                 r_armed;

  // Registered outputs
  logic [7:0]           r_data;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_serr;
  logic                 r_ovr;
  logic                 r_busy;

  assign w_rxs = r_sync2;

  // Bring the asynchronous rx pin into the clk domain; idle level is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Oversampling tick: one pulse every r_div+1 cycles while a frame is active
  assign w_tick = (r_state != S_IDLE) && (r_tick_cnt == r_div);

  // Tick counter; parked at zero in IDLE so START always begins a fresh period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= {DIV_WIDTH{1'b0}};
    end else if (r_state == S_IDLE) begin
      r_tick_cnt <= {DIV_WIDTH{1'b0}};
    end else if (w_tick) begin
      r_tick_cnt <= {DIV_WIDTH{1'b0}};
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] r_hist;

  // Keep the two previous tick samples for the majority vote
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist <= 2'b11;
    end else if (w_tick) begin
      r_hist <= {r_hist[0], w_rxs};
    end else begin
      r_hist <= r_hist;
    end
  end

  assign w_bit = maj3(r_hist[1], r_hist[0], w_rxs);
`else
  assign w_bit = w_rxs;
`endif

  // Parity is enabled only for codes 01 (even) and 10 (odd).
  // The last data bit index is N-1 = 4 + data_bits_count.
  assign w_par_en   = (r_par_type == 2'b01) || (r_par_type == 2'b10);
  assign w_last_idx = {1'b1, r_dbc};

  // Receive FSM: framing, bit assembly, error flags and delivery pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_samp_cnt <= {SCW{1'b0}};
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_div      <= {DIV_WIDTH{1'b0}};
      r_par_type <= 2'b00;
      r_dbc      <= 2'b00;
      r_two_stop <= 1'b0;
      r_par_err  <= 1'b0;
      r_stop_err <= 1'b0;
      r_armed    <= 1'b0;
      r_data     <= 8'h00;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_serr     <= 1'b0;
      r_ovr      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses unless DONE raises them
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_serr  <= 1'b0;
      r_ovr   <= 1'b0;

      if (!en) begin
        // Silent abort. Re-arm only once the line has been seen high, so a
        // frame cut off during a low bit is not mistaken for a start edge.
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_armed <= r_armed | w_rxs;
      end else begin
        case (r_state)
          S_IDLE: begin
            // Arming after a high level stops a held-low break line from
            // restarting frames forever.
            r_armed <= r_armed | w_rxs;
            if (r_armed && !w_rxs) begin
              r_state    <= S_START;
              r_busy     <= 1'b1;
              r_samp_cnt <= {SCW{1'b0}};
              r_bit_cnt  <= 3'd0;
              r_shift    <= 8'h00;
              r_par_err  <= 1'b0;
              r_stop_err <= 1'b0;
              r_armed    <= 1'b0;
              r_div      <= clock_divisor;
              r_par_type <= parity_type;
              r_dbc      <= data_bits_count;
              r_two_stop <= double_stop_bits;
            end else begin
              r_state <= S_IDLE;
            end
          end

          S_START: begin
            if (w_tick) begin
              if (r_samp_cnt == START_DECIDE) begin
                if (w_bit) begin
                  // Line is high again at mid start bit: a glitch, not a frame
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                end else begin
                  r_state    <= S_DATA;
                  r_samp_cnt <= {SCW{1'b0}};
                  r_bit_cnt  <= 3'd0;
                end
              end else begin
                r_samp_cnt <= r_samp_cnt + 1'b1;
              end
            end
          end

          S_DATA: begin
            if (w_tick) begin
              if (r_samp_cnt == BIT_LAST) begin
                r_samp_cnt         <= {SCW{1'b0}};
                r_shift[r_bit_cnt] <= w_bit;
                if (r_bit_cnt == w_last_idx) begin
                  r_state <= w_par_en ? S_PARITY : S_STOP1;
                end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                end
              end else begin
                r_samp_cnt <= r_samp_cnt + 1'b1;
              end
            end
          end

          S_PARITY: begin
            if (w_tick) begin
              if (r_samp_cnt == BIT_LAST) begin
                r_samp_cnt <= {SCW{1'b0}};
                // Total XOR must be 0 for even and 1 for odd (code 10)
                r_par_err  <= (par8(r_shift) ^ w_bit) != (r_par_type == 2'b10);
                r_state    <= S_STOP1;
              end else begin
                r_samp_cnt <= r_samp_cnt + 1'b1;
              end
            end
          end

          S_STOP1: begin
            if (w_tick) begin
              if (r_samp_cnt == BIT_LAST) begin
                r_samp_cnt <= {SCW{1'b0}};
                if (!w_bit) begin
                  r_stop_err <= 1'b1;
                end
                r_state <= r_two_stop ? S_STOP2 : S_DONE;
              end else begin
                r_samp_cnt <= r_samp_cnt + 1'b1;
              end
            end
          end

          S_STOP2: begin
            if (w_tick) begin
              if (r_samp_cnt == BIT_LAST) begin
                r_samp_cnt <= {SCW{1'b0}};
                if (!w_bit) begin
                  r_stop_err <= 1'b1;
                end
                r_state <= S_DONE;
              end else begin
                r_samp_cnt <= r_samp_cnt + 1'b1;
              end
            end
          end

          S_DONE: begin
            // Deliver even with errors; a full queue turns delivery into overrun
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_perr  <= r_par_err;
            r_serr  <= r_stop_err;
            if (ready) begin
              r_valid <= 1'b1;
              r_data  <= r_shift;
            end else begin
              r_ovr <= 1'b1;
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data           = r_data;
  assign valid          = r_valid;
  assign parity_error   = r_perr;
  assign stop_bit_error = r_serr;
  assign overrun        = r_ovr;
  assign busy           = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx - directed bench for uart_rx with hand-computed expectations.
`timescale 1ns/1ps

module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       en;
  logic [4:0] clock_divisor;
  logic [1:0] parity_type;
  logic [1:0] data_bits_count;
  logic       double_stop_bits;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       parity_error;
  logic       stop_bit_error;
  logic       overrun;
  logic       busy;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int LAT_8N1 = 157;
  localparam int LAT_5O2 = 552;
`else
  localparam int LAT_8N1 = 156;
  localparam int LAT_5O2 = 548;
`endif

  always #5 clk = ~clk;

  uart_rx #(.OVERSAMPLE(16), .DIV_WIDTH(5)) dut (
    .clk              (clk),
    .reset            (reset),
    .rx               (rx),
    .en               (en),
    .clock_divisor    (clock_divisor),
    .parity_type      (parity_type),
    .data_bits_count  (data_bits_count),
    .double_stop_bits (double_stop_bits),
    .ready            (ready),
    .data             (data),
    .valid            (valid),
    .parity_error     (parity_error),
    .stop_bit_error   (stop_bit_error),
    .overrun          (overrun),
    .busy             (busy)
  );

  int checks   = 0;
  int failures = 0;

  int         cyc     = 0;
  int         n_valid = 0;
  int         n_perr  = 0;
  int         n_serr  = 0;
  int         n_ovr   = 0;
  int         t_valid = 0;
  int         t_perr  = 0;
  logic [7:0] last_data = 8'h00;

  int v0, p0, s0, o0;
  bit ball;
  int ts;
  logic [7:0] exp_hold;

  // Free-running cycle count on the active edge
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (valid) begin
      n_valid   <= n_valid + 1;
      last_data <= data;
      t_valid   <= cyc;
    end
    if (parity_error) begin
      n_perr <= n_perr + 1;
      t_perr <= cyc;
    end
    if (stop_bit_error) n_serr <= n_serr + 1;
    if (overrun)        n_ovr  <= n_ovr + 1;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks = checks + 1;
    if (obs != exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    v0 = n_valid;
    p0 = n_perr;
    s0 = n_serr;
    o0 = n_ovr;
  endtask

  // par: 0 none, 1 even, 2 odd. glitch_bit: data bit to glitch (-1 none).
  // abort_after: number of frame bits to drive before stopping (0 = whole frame).
  task automatic send_frame(input logic [7:0] d, input int nbits, input int par,
                            input bit bad_par, input int nstop, input bit stop2_val,
                            input int bitlen, input int glitch_bit, input int abort_after,
                            output bit busy_all, output int t_start);
    logic [11:0] fb;
    int n;
    int nb;
    logic p;
    fb = 12'h000;
    n = 0;
    fb[n] = 1'b0;
    n = n + 1;
    for (int i = 0; i < nbits; i++) begin
      fb[n] = d[i];
      n = n + 1;
    end
    if (par != 0) begin
      p = (^d) ^ (par == 2) ^ bad_par;
      fb[n] = p;
      n = n + 1;
    end
    fb[n] = 1'b1;
    n = n + 1;
    if (nstop == 2) begin
      fb[n] = stop2_val;
      n = n + 1;
    end
    nb = (abort_after > 0) ? abort_after : n;
    busy_all = 1'b1;
    @(negedge clk);
    t_start = cyc;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < bitlen; c++) begin
        rx = fb[b];
        if (glitch_bit >= 0 && b == glitch_bit + 1 && c == bitlen / 2) rx = ~fb[b];
        if (c == bitlen / 2 && b < n - 1) busy_all = busy_all & busy;
        @(negedge clk);
      end
    end
    rx = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    en = 1'b1;
    clock_divisor = 5'd0;
    parity_type = 2'b00;
    data_bits_count = 2'b11;
    double_stop_bits = 1'b0;
    ready = 1'b1;
    idle(3);
    check_eq("rst_data", data, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_flags", {parity_error, stop_bit_error, overrun}, 0);
    reset = 1'b0;
    idle(5);

    // 8N1, divisor 0, 0xA5
    snap();
    send_frame(8'hA5, 8, 0, 1'b0, 1, 1'b1, 16, -1, 0, ball, ts);
    idle(4);
    check_eq("8n1_valid", n_valid - v0, 1);
    check_eq("8n1_data", last_data, 8'hA5);
    check_eq("8n1_perr", n_perr - p0, 0);
    check_eq("8n1_serr", n_serr - s0, 0);
    check_eq("8n1_latency", t_valid - ts, LAT_8N1);
    check_eq("8n1_busy", ball, 1);
    idle(5);

    // 7E1, 0x35, correct then wrong parity
    parity_type = 2'b01;
    data_bits_count = 2'b10;
    snap();
    send_frame(8'h35, 7, 1, 1'b0, 1, 1'b1, 16, -1, 0, ball, ts);
    idle(4);
    check_eq("7e1_valid", n_valid - v0, 1);
    check_eq("7e1_data", last_data, 8'h35);
    check_eq("7e1_perr", n_perr - p0, 0);
    snap();
    send_frame(8'h35, 7, 1, 1'b1, 1, 1'b1, 16, -1, 0, ball, ts);
    idle(4);
    check_eq("7e1bad_valid", n_valid - v0, 1);
    check_eq("7e1bad_data", last_data, 8'h35);
    check_eq("7e1bad_perr", n_perr - p0, 1);
    check_eq("7e1bad_same_cycle", t_perr - t_valid, 0);
    idle(5);

    // 5O2, divisor 3, second stop bit low
    clock_divisor = 5'd3;
    parity_type = 2'b10;
    data_bits_count = 2'b00;
    double_stop_bits = 1'b1;
    snap();
    send_frame(8'h1F, 5, 2, 1'b0, 2, 1'b0, 64, -1, 0, ball, ts);
    idle(10);
    check_eq("5o2_valid", n_valid - v0, 1);
    check_eq("5o2_data", last_data, 8'h1F);
    check_eq("5o2_serr", n_serr - s0, 1);
    check_eq("5o2_perr", n_perr - p0, 0);
    check_eq("5o2_latency", t_valid - ts, LAT_5O2);
    exp_hold = 8'h1F;

    // False start: 6-cycle low pulse at divisor 0
    clock_divisor = 5'd0;
    parity_type = 2'b00;
    data_bits_count = 2'b11;
    double_stop_bits = 1'b0;
    idle(5);
    snap();
    rx = 1'b0;
    idle(6);
    rx = 1'b1;
    idle(30);
    check_eq("false_valid", n_valid - v0, 0);
    check_eq("false_errs", (n_perr - p0) + (n_serr - s0), 0);
    check_eq("false_busy", busy, 0);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // One-cycle high glitch in the middle of data bit 3 of 0x00
    snap();
    send_frame(8'h00, 8, 0, 1'b0, 1, 1'b1, 16, 3, 0, ball, ts);
    idle(4);
    check_eq("vote_valid", n_valid - v0, 1);
    check_eq("vote_data", last_data, 8'h00);
    exp_hold = 8'h00;
    idle(5);
`endif

    // Overrun with ready low, then a clean frame
    ready = 1'b0;
    snap();
    send_frame(8'h3C, 8, 0, 1'b0, 1, 1'b1, 16, -1, 0, ball, ts);
    idle(4);
    check_eq("ovr_pulse", n_ovr - o0, 1);
    check_eq("ovr_valid", n_valid - v0, 0);
    check_eq("ovr_data_hold", data, exp_hold);
    ready = 1'b1;
    idle(5);
    snap();
    send_frame(8'hC3, 8, 0, 1'b0, 1, 1'b1, 16, -1, 0, ball, ts);
    idle(4);
    check_eq("post_ovr_valid", n_valid - v0, 1);
    check_eq("post_ovr_data", last_data, 8'hC3);
    idle(5);

    // Reset in the middle of the data bits
    send_frame(8'h55, 8, 0, 1'b0, 1, 1'b1, 16, 3, 3, ball, ts);
    reset = 1'b1;
    idle(2);
    check_eq("midrst_data", data, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_pulses", {valid, parity_error, stop_bit_error, overrun}, 0);
    reset = 1'b0;
    idle(10);
    snap();
    send_frame(8'h81, 8, 0, 1'b0, 1, 1'b1, 16, -1, 0, ball, ts);
    idle(4);
    check_eq("after_rst_valid", n_valid - v0, 1);
    check_eq("after_rst_data", last_data, 8'h81);
    idle(5);

    // Drop en mid-frame
    snap();
    send_frame(8'h5A, 8, 0, 1'b0, 1, 1'b1, 16, -1, 4, ball, ts);
    en = 1'b0;
    idle(1);
    check_eq("en_drop_busy", busy, 0);
    idle(200);
    check_eq("en_drop_pulses", (n_valid - v0) + (n_perr - p0) + (n_serr - s0) + (n_ovr - o0), 0);
    en = 1'b1;
    idle(5);
    snap();
    send_frame(8'h0F, 8, 0, 1'b0, 1, 1'b1, 16, -1, 0, ball, ts);
    idle(4);
    check_eq("after_en_data", last_data, 8'h0F);
    check_eq("after_en_valid", n_valid - v0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive front end of the UART peripheral.
- Synchronises the rx pin, oversamples it 16x at a rate set by the 5-bit clock divisor, deframes 5–8 data bits with optional parity and 1 or 2 stop bits, and delivers each byte to the RX queue.
- Per-frame parity and stop-bit error pulses feed the interrupt-flag registers in uart_top.

Parameters:
- OVERSAMPLE, 16, sample ticks per bit; must be even and >= 4.
- DIV_WIDTH, 5, width of clock_divisor.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  raw serial line; idle high.
- en  input  1  receiver enable; low aborts and holds IDLE.
- clock_divisor  input  DIV_WIDTH  sample tick every clock_divisor+1 clk cycles.
- parity_type  input  2  00 none, 01 even, 10 odd, 11 none.
- data_bits_count  input  2  00=5, 01=6, 10=7, 11=8 data bits.
- double_stop_bits  input  1  1 = two stop bits.
- ready  input  1  RX queue can accept (not full).
- data  output  8  received byte, LSB-aligned, unused MSBs zero.
- valid  output  1  one-cycle pulse; data written to queue.
- parity_error  output  1  one-cycle pulse with frame end.
- stop_bit_error  output  1  one-cycle pulse with frame end.
- overrun  output  1  one-cycle pulse; frame dropped because ready was low.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (async):
  - State IDLE; synchroniser FFs = 1.
  - Tick counter, sample counter, bit counter, shift register = 0.
  - Outputs valid, parity_error, stop_bit_error, overrun, busy = 0; data = 0.
- Synchroniser: 2 FFs on rx. All decisions use the second-stage output rxs.
- Tick generator:
  - Counter runs 0..clock_divisor; tick is asserted for one cycle when count == clock_divisor, then the counter wraps to 0.
  - Counter is cleared on the IDLE->START transition.
  - Bit period = OVERSAMPLE*(clock_divisor+1) cycles.
- Config latch: clock_divisor, parity_type, data_bits_count and double_stop_bits are latched on IDLE->START. Changes mid-frame have no effect until the next frame.
- FSM:
  - IDLE: if en && rxs==0, go to START and clear the sample counter.
  - START: count ticks. At tick OVERSAMPLE/2-1 (mid start bit), sample. If sample is 1, treat as a false start and return to IDLE with no output. Otherwise clear the sample counter, go to DATA, set bit counter = 0.
  - DATA: on every OVERSAMPLE-th tick, sample and shift into bit[bit counter] (LSB first). After the N-th bit, go to PARITY if parity is enabled, else STOP1.
  - PARITY: sample one bit. Error if XOR(data bits, parity bit) != 0 for even, or != 1 for odd.
  - STOP1: sample. A 0 sets the stop-error flag. Go to STOP2 if double_stop_bits, else DONE.
  - STOP2: sample. A 0 sets the stop-error flag. Go to DONE.
  - DONE: one cycle, then IDLE.
    - If ready: valid=1, data = assembled byte.
    - If not ready: overrun=1, valid=0, data unchanged.
    - parity_error and stop_bit_error pulse in this cycle in both cases.
    - The byte is delivered even when an error flag is set.
- Timing:
  - The frame ends at mid final stop bit, so the next start edge can be detected immediately.
  - Latency from rx edge to START is 2–3 cycles.
- Error flags are cleared on entry to START.
- en low in any state: go to IDLE in the next cycle and abort the frame silently (no pulses).
- Break (rx held low): frame completes with stop_bit_error. The receiver then re-enters START only after rxs has returned high, i.e. after seeing 1 in IDLE.
- Unused data MSBs are forced to 0 for 5–7 bit frames.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined:
  - Each bit value (start, data, parity, stop) is the 2-of-3 majority of samples at ticks OVERSAMPLE/2-2, OVERSAMPLE/2-1 and OVERSAMPLE/2.
  - A single-tick glitch is ignored.
  - The false-start check also uses the majority vote.
- Undefined: a single sample at tick OVERSAMPLE/2-1. No vote logic is synthesised.

Test Plan:
- 8N1 (divisor 0, bit = 16 cycles), ready=1, send 0xA5 -> one valid pulse with data=0xA5, no errors, about 154±3 cycles after the start edge; busy high throughout.
- 7E1, send 0x35 with correct parity bit 0 -> valid, data=0x35, parity_error=0. Repeat with parity bit 1 -> valid, data=0x35, parity_error=1 in the same cycle.
- 5O2, divisor 3, send 0x1F with second stop bit driven 0 -> data=0x1F, stop_bit_error=1. Check bit period = 64 cycles.
- 6-cycle low pulse on idle line (divisor 0) -> returns to IDLE, no valid, no error pulses. With UART_RX_MAJORITY_VOTE_EN, a 1-cycle high glitch mid data bit leaves the byte uncorrupted.
- Frame 0x3C with ready=0 at DONE -> overrun=1, valid=0. The next frame 0xC3 with ready=1 is received correctly.
- Assert reset mid DATA, then release and send 0x81 -> all outputs 0 during reset; 0x81 received cleanly. Separately, dropping en mid-frame -> no pulses, busy=0 within 1 cycle.
